hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage core; sits beside the forwarding logic and drives per-stage load enables and bubble/flush controls.
- Covers the hazards forwarding cannot resolve: load-use (EX->ID), instruction/data cache misses, and taken-branch redirects from EX.
- Tracks split cache completions so one cache's response is not lost while the other cache is still stalled.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 32, perf-counter width (used only with the optional feature)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- ifid_rs1  in  REG_W  rs1 index of instruction in IF/ID
- ifid_rs2  in  REG_W  rs2 index of instruction in IF/ID
- ifid_uses_rs1  in  1  IF/ID instruction reads rs1
- ifid_uses_rs2  in  1  IF/ID instruction reads rs2
- idex_rd  in  REG_W  destination of instruction in ID/EX
- idex_mem_read  in  1  ID/EX instruction is a load
- icache_read  in  1  fetch request active
- icache_resp  in  1  fetch completes this cycle
- dcache_req  in  1  EX/MEM read or write active
- dcache_resp  in  1  data access completes this cycle
- br_taken  in  1  EX-stage redirect (branch taken / jump)
- pc_load  out  1  PC enable
- ifid_load  out  1  IF/ID register enable
- idex_load  out  1  ID/EX register enable
- exmem_load  out  1  EX/MEM register enable
- memwb_load  out  1  MEM/WB register enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_flush  out  1  ID/EX loads NOP (bubble)
- stall_cycles  out  CNT_W  mem-stall cycle count (optional feature)
- lu_bubbles  out  CNT_W  load-use bubble count (optional feature)
- flushes  out  CNT_W  redirect count (optional feature)

Behaviour:
- Reset (rst low, async): state=RUN, i_done=d_done=0.
  - Every *_load output = 0, every *_flush output = 0, counters = 0.
  - After rst deasserts, outputs follow the rules below from the first clk edge.
- State: i_done and d_done latches; FSM states RUN and STALL, held in a shared enum.
- Miss terms:
  - imiss = icache_read & ~icache_resp & ~i_done
  - dmiss = dcache_req & ~dcache_resp & ~d_done
  - mem_stall = imiss | dmiss
- Priority, evaluated combinationally each cycle (zero latency):
  1. mem_stall: all five loads = 0, both flushes = 0. Freeze whole pipe.
  2. br_taken: all loads = 1, ifid_flush = 1, idex_flush = 1. Overrides load-use, because the dependent instruction is wrong-path.
  3. Load-use: idex_mem_read & idex_rd!=0 & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd)).
     - pc_load = 0, ifid_load = 0; idex_load = 1 with idex_flush = 1; exmem_load = 1, memwb_load = 1.
     - Exactly one bubble per event: the bubble clears idex_mem_read, so the hazard does not re-fire.
  4. Otherwise: all loads = 1, no flush.
- FSM transitions:
  - RUN->STALL on mem_stall.
  - STALL->RUN on ~mem_stall.
  - RUN->RUN otherwise.
- Split completion: in STALL, or on the RUN->STALL edge:
  - icache_resp while dmiss is still pending sets i_done.
  - dcache_resp while imiss is still pending sets d_done.
  - Both latches clear on the clock edge that leaves STALL.
- Simultaneous icache_resp and dcache_resp: stall ends that cycle, and no latch is set.
- br_taken during a stall is held by the frozen ID/EX and takes effect in the release cycle. No separate latch is required.
- rs index 0 never raises a load-use hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: three CNT_W saturating counters.
  - stall_cycles increments each mem_stall cycle.
  - lu_bubbles increments each load-use bubble.
  - flushes increments each br_taken cycle not under stall.
  - All three are cleared by rst.
- Undefined: counter ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared types package: hazard_state_t enum {RUN, STALL} and REG_W constant, placed with the other pipeline typedefs.
- Sub-module hazard_perf_counter (one saturating counter with increment and reset), instantiated three times under the macro.

Test Plan:
- Load-use: ID/EX `lw x5`, IF/ID `add x6,x5,x1` with uses_rs1=1, no stalls -> exactly one cycle with pc_load=0, ifid_load=0, idex_flush=1; next cycle all loads=1; lu_bubbles=1.
- Load to x0: ID/EX `lw x0`, IF/ID reads x0 -> no bubble, all loads=1.
- Branch vs load-use: br_taken=1 with load-use pattern present -> ifid_flush=1, idex_flush=1, pc_load=1, no bubble-only cycle; flushes=1.
- Split completion: icache_read and dcache_req both missing.
  - icache_resp at cycle 3 -> i_done=1, loads stay 0.
  - dcache_resp at cycle 7 -> loads=1 in cycle 7; RUN at cycle 8 with i_done=0; stall_cycles=7.
- Branch under stall: dmiss for 4 cycles with br_taken=1 held -> no flush during stall; flushes asserted in the release cycle only.
- Async reset mid-STALL: drop rst between clk edges -> outputs 0 immediately, state=RUN, latches and counters 0.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline-control types: sequencing FSM states and the register-index width.
package hazard_controller_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Single saturating event counter; holds at all-ones instead of wrapping.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: memory-miss freeze, branch redirect flush, load-use bubble.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int REG_W = hazard_controller_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_mem_read,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic             br_taken,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] lu_bubbles,
  output logic [CNT_W-1:0] flushes
);
  import hazard_controller_pkg::*;

  hazard_state_t state_q, state_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          imiss, dmiss, mem_stall, load_use;

  // A cache that already answered during this stall episode no longer counts as missing.
  assign imiss     = icache_read & ~icache_resp & ~i_done_q;
  assign dmiss     = dcache_req  & ~dcache_resp & ~d_done_q;
  assign mem_stall = imiss | dmiss;

  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_done_d   = i_done_q;
    d_done_d   = d_done_q;
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    exmem_load = 1'b0;
    memwb_load = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    case (state_q)
      RUN:     if (mem_stall)  state_d = STALL;
      STALL:   if (!mem_stall) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Remember a completion that arrived while the other cache still holds the pipe.
    if ((state_q == STALL) && !mem_stall) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end else if ((state_q == STALL) || mem_stall) begin
      if (icache_resp && dmiss) i_done_d = 1'b1;
      if (dcache_resp && imiss) d_done_d = 1'b1;
    end

    // Outputs are forced low while reset is held; a memory stall freezes everything.
    if (rst && !mem_stall) begin
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      if (br_taken) begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic lu_evt, flush_evt;

  assign lu_evt    = load_use & ~mem_stall & ~br_taken;
  assign flush_evt = br_taken & ~mem_stall;

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_stall),
    .count (stall_cycles)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lu_evt),
    .count (lu_bubbles)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_evt),
    .count (flushes)
  );
`else
  assign stall_cycles = '0;
  assign lu_bubbles   = '0;
  assign flushes      = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized traffic vs a reference model.
module tb_hazard_controller;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] C_ZERO   = 7'b00000_00;
  localparam logic [6:0] C_RUN    = 7'b11111_00;
  localparam logic [6:0] C_BRANCH = 7'b11111_11;
  localparam logic [6:0] C_BUBBLE = 7'b00111_01;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] ifid_rs1, ifid_rs2, idex_rd;
  logic             ifid_uses_rs1, ifid_uses_rs2, idex_mem_read;
  logic             icache_read, icache_resp, dcache_req, dcache_resp, br_taken;
  logic             pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic             ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cycles, lu_bubbles, flushes;
  logic [6:0]       act;

  int checks = 0;
  int errors = 0;

  // reference model: which cache has been served in the current stall episode
  bit     m_in_stall, m_i_served, m_d_served;
  longint m_stall_cnt, m_lu_cnt, m_fl_cnt;

  hazard_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs1 (ifid_uses_rs1),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .idex_rd       (idex_rd),
    .idex_mem_read (idex_mem_read),
    .icache_read   (icache_read),
    .icache_resp   (icache_resp),
    .dcache_req    (dcache_req),
    .dcache_resp   (dcache_resp),
    .br_taken      (br_taken),
    .pc_load       (pc_load),
    .ifid_load     (ifid_load),
    .idex_load     (idex_load),
    .exmem_load    (exmem_load),
    .memwb_load    (memwb_load),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .stall_cycles  (stall_cycles),
    .lu_bubbles    (lu_bubbles),
    .flushes       (flushes)
  );

  assign act = {pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit m_wait_i();
    return icache_read && !icache_resp && !m_i_served;
  endfunction

  function automatic bit m_wait_d();
    return dcache_req && !dcache_resp && !m_d_served;
  endfunction

  function automatic bit m_lu();
    return idex_mem_read && (idex_rd != 0) &&
           ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd));
  endfunction

  function automatic logic [6:0] m_ctrl();
    if (m_wait_i() || m_wait_d()) return C_ZERO;
    if (br_taken)                 return C_BRANCH;
    if (m_lu())                   return C_BUBBLE;
    return C_RUN;
  endfunction

  function automatic logic [CNT_W-1:0] m_cnt(input longint v);
    return PERF ? CNT_W'(v) : '0;
  endfunction

  // Advance the model across one clock edge using the inputs that were held over it.
  task automatic m_step();
    bit wi, wd, s;
    wi = m_wait_i();
    wd = m_wait_d();
    s  = wi || wd;
    if (m_in_stall && !s) begin
      m_i_served = 1'b0;
      m_d_served = 1'b0;
    end else if (m_in_stall || s) begin
      if (icache_resp && wd) m_i_served = 1'b1;
      if (dcache_resp && wi) m_d_served = 1'b1;
    end
    if (s)             m_stall_cnt++;
    else if (br_taken) m_fl_cnt++;
    else if (m_lu())   m_lu_cnt++;
    m_in_stall = s;
  endtask

  task automatic m_reset();
    m_in_stall  = 1'b0;
    m_i_served  = 1'b0;
    m_d_served  = 1'b0;
    m_stall_cnt = 0;
    m_lu_cnt    = 0;
    m_fl_cnt    = 0;
  endtask

  task automatic idle_inputs();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    icache_read = 1'b0; icache_resp = 1'b0;
    dcache_req = 1'b0; dcache_resp = 1'b0; br_taken = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_step();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #2;
    checks++;
    if (act !== C_ZERO) begin
      errors++; $display("FAIL reset_outputs act=%b required=%b", act, C_ZERO);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({stall_cycles, lu_bubbles, flushes} !== '0) begin
      errors++; $display("FAIL reset_counters act=%0d/%0d/%0d required=0/0/0", stall_cycles, lu_bubbles, flushes);
    end
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    checks++;
    if (act !== C_RUN) begin
      errors++; $display("FAIL reset_release act=%b required=%b", act, C_RUN);
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd5;
    ifid_rs1 = 5'd5; ifid_uses_rs1 = 1'b1; ifid_rs2 = 5'd1; ifid_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== C_BUBBLE) begin
      errors++; $display("FAIL load_use_bubble act=%b required=%b", act, C_BUBBLE);
    end
    advance();
    idex_mem_read = 1'b0; idex_rd = 5'd0;
    ifid_rs1 = 5'd2; ifid_rs2 = 5'd3;
    @(negedge clk);
    checks++;
    if (act !== C_RUN) begin
      errors++; $display("FAIL load_use_after act=%b required=%b", act, C_RUN);
    end
    advance();
    checks++;
    if (lu_bubbles !== m_cnt(1) || flushes !== m_cnt(0) || stall_cycles !== m_cnt(0)) begin
      errors++; $display("FAIL load_use_counters act=%0d/%0d/%0d required=%0d/0/0",
                         lu_bubbles, flushes, stall_cycles, m_cnt(1));
    end
  endtask

  task automatic test_load_x0();
    do_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd0;
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_uses_rs1 = 1'b1; ifid_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== C_RUN) begin
      errors++; $display("FAIL load_x0 act=%b required=%b", act, C_RUN);
    end
    advance();
    checks++;
    if (lu_bubbles !== m_cnt(0)) begin
      errors++; $display("FAIL load_x0_counter act=%0d required=0", lu_bubbles);
    end
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd7;
    ifid_rs2 = 5'd7; ifid_uses_rs2 = 1'b1; br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== C_BRANCH) begin
      errors++; $display("FAIL branch_over_lu act=%b required=%b", act, C_BRANCH);
    end
    advance();
    br_taken = 1'b0; idex_mem_read = 1'b0; idex_rd = 5'd0; ifid_uses_rs2 = 1'b0;
    @(negedge clk);
    checks++;
    if (act !== C_RUN) begin
      errors++; $display("FAIL branch_after act=%b required=%b", act, C_RUN);
    end
    advance();
    checks++;
    if (flushes !== m_cnt(1) || lu_bubbles !== m_cnt(0)) begin
      errors++; $display("FAIL branch_counters act=%0d/%0d required=%0d/0", flushes, lu_bubbles, m_cnt(1));
    end
  endtask

  task automatic test_split_completion();
    do_reset();
    icache_read = 1'b1; dcache_req = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      icache_resp = (c == 3);
      dcache_resp = (c == 7);
      if (c == 8) dcache_req = 1'b0;
      @(negedge clk);
      checks++;
      if (act !== ((c == 7) ? C_RUN : C_ZERO)) begin
        errors++; $display("FAIL split_cycle%0d act=%b required=%b", c, act, (c == 7) ? C_RUN : C_ZERO);
      end
      advance();
      if (c == 7) begin
        checks++;
        if (stall_cycles !== m_cnt(7)) begin
          errors++; $display("FAIL split_stall_cycles act=%0d required=%0d", stall_cycles, m_cnt(7));
        end
      end
    end
    icache_read = 1'b0; icache_resp = 1'b0; dcache_resp = 1'b0;
  endtask

  task automatic test_branch_under_stall();
    do_reset();
    dcache_req = 1'b1; br_taken = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      dcache_resp = (c == 4);
      @(negedge clk);
      checks++;
      if (act !== ((c == 4) ? C_BRANCH : C_ZERO)) begin
        errors++; $display("FAIL br_stall_cycle%0d act=%b required=%b", c, act, (c == 4) ? C_BRANCH : C_ZERO);
      end
      advance();
    end
    checks++;
    if (flushes !== m_cnt(1) || stall_cycles !== m_cnt(4)) begin
      errors++; $display("FAIL br_stall_counters act=%0d/%0d required=%0d/%0d",
                         flushes, stall_cycles, m_cnt(1), m_cnt(4));
    end
    dcache_req = 1'b0; dcache_resp = 1'b0; br_taken = 1'b0;
  endtask

  task automatic test_async_reset_mid_stall();
    do_reset();
    icache_read = 1'b1; dcache_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      icache_resp = (c == 1);
      advance();
    end
    icache_resp = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (act !== C_ZERO || {stall_cycles, lu_bubbles, flushes} !== '0) begin
      errors++; $display("FAIL async_reset act=%b/%0d required=%b/0", act, stall_cycles, C_ZERO);
    end
    dcache_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    checks++;
    if (act !== C_ZERO) begin
      errors++; $display("FAIL async_reset_latch act=%b required=%b", act, C_ZERO);
    end
    advance();
    icache_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (act !== C_RUN) begin
      errors++; $display("FAIL async_reset_resume act=%b required=%b", act, C_RUN);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      icache_read   = ($urandom_range(0, 99) < 50);
      icache_resp   = ($urandom_range(0, 99) < 30);
      dcache_req    = ($urandom_range(0, 99) < 40);
      dcache_resp   = ($urandom_range(0, 99) < 30);
      br_taken      = ($urandom_range(0, 99) < 15);
      idex_mem_read = ($urandom_range(0, 99) < 50);
      ifid_uses_rs1 = ($urandom_range(0, 99) < 70);
      ifid_uses_rs2 = ($urandom_range(0, 99) < 50);
      idex_rd       = REG_W'($urandom_range(0, 3));
      ifid_rs1      = REG_W'($urandom_range(0, 3));
      ifid_rs2      = REG_W'($urandom_range(0, 3));
      @(negedge clk);
      exp = m_ctrl();
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL random_ctrl n=%0d act=%b required=%b", n, act, exp);
      end
      advance();
      checks++;
      if (stall_cycles !== m_cnt(m_stall_cnt) || lu_bubbles !== m_cnt(m_lu_cnt) ||
          flushes !== m_cnt(m_fl_cnt)) begin
        errors++; $display("FAIL random_counters n=%0d act=%0d/%0d/%0d required=%0d/%0d/%0d", n,
                           stall_cycles, lu_bubbles, flushes,
                           m_cnt(m_stall_cnt), m_cnt(m_lu_cnt), m_cnt(m_fl_cnt));
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_load_use();
    test_load_x0();
    test_branch_vs_load_use();
    test_split_completion();
    test_branch_under_stall();
    test_async_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
